// File: rtl/serial_port_router.sv
// Serial frame router: decodes a port/length header from a bit stream and steers
// the payload bits onto one of 2**PORT_W output channels, with optional even parity.
module serial_port_router #(
    parameter int unsigned PORT_W    = 2,
    parameter int unsigned LEN_W     = 4,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     ser_in_i,
    output logic [(2**PORT_W)-1:0]   port_data_o,
    output logic [(2**PORT_W)-1:0]   port_valid_o,
    output logic [PORT_W-1:0]        cur_port_o,
    output logic [LEN_W-1:0]         cur_len_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int unsigned N_PORTS = 2 ** PORT_W;
    localparam int unsigned CNT_W   = (PORT_W > LEN_W) ? PORT_W : LEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_PORT,
        S_HDR_LEN,
        S_PAYLOAD,
        S_PARITY,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 par_q;
    logic [PORT_W-1:0]    cur_port_q;
    logic [LEN_W-1:0]     cur_len_q;
    logic [N_PORTS-1:0]   port_data_q;
    logic [N_PORTS-1:0]   port_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic [PORT_W-1:0]    port_shift_d;
    logic [LEN_W-1:0]     len_shift_d;
    logic [N_PORTS-1:0]   port_sel_d;
    logic                 last_bit_d;

    // Header fields shift in MSB-first; the counter marks the last bit of each field.
    assign port_shift_d = PORT_W'({cur_port_q, ser_in_i});
    assign len_shift_d  = LEN_W'({cur_len_q, ser_in_i});
    assign port_sel_d   = N_PORTS'(1) << cur_port_q;
    assign last_bit_d   = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            cur_port_q   <= '0;
            cur_len_q    <= '0;
            port_data_q  <= '0;
            port_valid_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Strobes last a single clk regardless of how long en stays high.
            port_data_q  <= '0;
            port_valid_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            if (en_i) begin
                case (state_q)
                    S_IDLE: begin
                        if (!ser_in_i) begin
                            state_q <= S_HDR_PORT;
                            cnt_q   <= CNT_W'(PORT_W - 1);
                            par_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_HDR_PORT: begin
                        cur_port_q <= port_shift_d;
                        par_q      <= par_q ^ ser_in_i;
                        if (last_bit_d) begin
                            state_q <= S_HDR_LEN;
                            cnt_q   <= CNT_W'(LEN_W - 1);
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_HDR_LEN: begin
                        cur_len_q <= len_shift_d;
                        par_q     <= par_q ^ ser_in_i;
                        if (last_bit_d) begin
                            if (len_shift_d != '0) begin
                                state_q <= S_PAYLOAD;
                                cnt_q   <= CNT_W'(len_shift_d) - CNT_W'(1);
                            end else if (PARITY_EN) begin
                                state_q <= S_PARITY;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= S_DONE;
                                cnt_q   <= '0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_PAYLOAD: begin
                        port_valid_q <= port_sel_d;
                        port_data_q  <= ser_in_i ? port_sel_d : '0;
                        par_q        <= par_q ^ ser_in_i;
                        if (last_bit_d) begin
                            cnt_q <= '0;
                            if (PARITY_EN) begin
                                state_q <= S_PARITY;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        err_q   <= PARITY_EN & (par_q ^ ser_in_i);
                    end
                    S_DONE: begin
                        // A zero here is the start bit of a back-to-back frame.
                        if (!ser_in_i) begin
                            state_q <= S_HDR_PORT;
                            cnt_q   <= CNT_W'(PORT_W - 1);
                            par_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign port_data_o  = port_data_q;
    assign port_valid_o = port_valid_q;
    assign cur_port_o   = cur_port_q;
    assign cur_len_o    = cur_len_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_serial_port_router.sv
// Directed bench for serial_port_router: default instance (A) plus a
// PORT_W=3 / LEN_W=5 / no-parity instance (B).
module tb_serial_port_router;

    logic       clk;
    logic       rst;
    logic       en_a, ser_a, en_b, ser_b;
    logic [3:0] pd_a, pv_a;
    logic [1:0] cp_a;
    logic [3:0] cl_a;
    logic       busy_a, done_a, err_a;
    logic [7:0] pd_b, pv_b;
    logic [2:0] cp_b;
    logic [4:0] cl_b;
    logic       busy_b, done_b, err_b;

    int         errors = 0;
    int         checks = 0;
    int         vcnt_a [4];
    logic [7:0] bits_a [4];
    int         vcnt_b [8];
    logic [7:0] bits_b [8];
    int         done_a_cnt, err_a_cnt, done_b_cnt, err_b_cnt;
    int         stray, busy_samp, busy_drops, done_idx;
    logic       track_busy;

    serial_port_router dut_a (
        .clk(clk), .rst(rst), .en_i(en_a), .ser_in_i(ser_a),
        .port_data_o(pd_a), .port_valid_o(pv_a), .cur_port_o(cp_a), .cur_len_o(cl_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    serial_port_router #(.PORT_W(3), .LEN_W(5), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en_i(en_b), .ser_in_i(ser_b),
        .port_data_o(pd_b), .port_valid_o(pv_b), .cur_port_o(cp_b), .cur_len_o(cl_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) begin vcnt_a[c] = 0; bits_a[c] = '0; end
        for (int c = 0; c < 8; c++) begin vcnt_b[c] = 0; bits_b[c] = '0; end
        done_a_cnt = 0; err_a_cnt = 0; done_b_cnt = 0; err_b_cnt = 0;
        stray = 0; busy_samp = 0; busy_drops = 0; done_idx = -1;
    endtask

    // Advance one clk and record outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++)
            if (pv_a[c]) begin vcnt_a[c]++; bits_a[c] = {bits_a[c][6:0], pd_a[c]}; end
        for (int c = 0; c < 8; c++)
            if (pv_b[c]) begin vcnt_b[c]++; bits_b[c] = {bits_b[c][6:0], pd_b[c]}; end
        if ((pd_a & ~pv_a) != 4'd0 || (pd_b & ~pv_b) != 8'd0) stray++;
        if ($countones(pv_a) > 1 || $countones(pv_b) > 1) stray++;
        if (done_a) done_a_cnt++;
        if (err_a) begin
            if (done_a) err_a_cnt++;
            else stray++;
        end
        if (done_b) done_b_cnt++;
        if (err_b) err_b_cnt++;
        if (track_busy && !busy_a) busy_drops++;
    endtask

    // Send n bits MSB-first, one en sample each, followed by gap clks with en low.
    task automatic frame(input bit sel_b, input logic [31:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            if (!sel_b && busy_a) busy_samp++;
            if (sel_b) begin ser_b = bits[i]; en_b = 1'b1; end
            else       begin ser_a = bits[i]; en_a = 1'b1; end
            tick();
            if (sel_b ? done_b : done_a) done_idx = n - 1 - i;
            en_a = 1'b0; en_b = 1'b0; ser_a = 1'b1; ser_b = 1'b1;
            repeat (gap) tick();
        end
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ser_a = 1'b1; ser_b = 1'b1;
        track_busy = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_a", 32'(pv_a), 0);
        chk("rst_data_a",  32'(pd_a), 0);
        chk("rst_port_a",  32'(cp_a), 0);
        chk("rst_len_a",   32'(cl_a), 0);
        chk("rst_flags_a", 32'({busy_a, done_a, err_a}), 0);
        chk("rst_flags_b", 32'({busy_b, done_b, err_b, pv_b}), 0);
        rst = 1'b0;
        tick(); tick();

        // Idle ones must not start a frame.
        frame(1'b0, 32'h1, 1, 3);
        chk("idle_busy", 32'(busy_a), 0);

        // Nominal frame: port 2, len 3, payload 101, parity 1.
        clear_counts();
        frame(1'b0, 32'(11'b0_10_0011_101_1), 11, 3);
        chk("nom_busy_in_done", 32'(busy_a), 1);
        frame(1'b0, 32'h1, 1, 3);
        chk("nom_vcnt2",  32'(vcnt_a[2]), 3);
        chk("nom_bits2",  32'(bits_a[2][2:0]), 32'h5);
        chk("nom_others", 32'(vcnt_a[0] + vcnt_a[1] + vcnt_a[3]), 0);
        chk("nom_port",   32'(cp_a), 2);
        chk("nom_len",    32'(cl_a), 3);
        chk("nom_done",   32'(done_a_cnt), 1);
        chk("nom_done_at_parity", 32'(done_idx), 10);
        chk("nom_err",    32'(err_a_cnt), 0);
        chk("nom_stray",  32'(stray), 0);
        chk("nom_busy_end", 32'(busy_a), 0);

        // Parity error: same frame, trailer 0.
        clear_counts();
        frame(1'b0, 32'(11'b0_10_0011_101_0), 11, 3);
        frame(1'b0, 32'h1, 1, 3);
        chk("perr_vcnt2", 32'(vcnt_a[2]), 3);
        chk("perr_bits2", 32'(bits_a[2][2:0]), 32'h5);
        chk("perr_done",  32'(done_a_cnt), 1);
        chk("perr_err_with_done", 32'(err_a_cnt), 1);
        chk("perr_stray", 32'(stray), 0);

        // Zero length: port 3, len 0, parity 0.
        clear_counts();
        frame(1'b0, 32'(8'b0_11_0000_0), 8, 3);
        frame(1'b0, 32'h1, 1, 3);
        chk("zl_valids", 32'(vcnt_a[0] + vcnt_a[1] + vcnt_a[2] + vcnt_a[3]), 0);
        chk("zl_done",   32'(done_a_cnt), 1);
        chk("zl_err",    32'(err_a_cnt), 0);
        chk("zl_busy_samples", 32'(busy_samp), 8);
        chk("zl_port",   32'(cp_a), 3);
        chk("zl_len",    32'(cl_a), 0);
        chk("zl_busy_end", 32'(busy_a), 0);

        // Back-to-back frames with en held high continuously.
        clear_counts();
        track_busy = 1'b1;
        frame(1'b0, 32'(11'b0_10_0011_101_1), 11, 0);
        frame(1'b0, 32'(9'b0_01_0001_1_1), 9, 0);
        track_busy = 1'b0;
        frame(1'b0, 32'h1, 1, 3);
        chk("b2b_vcnt2", 32'(vcnt_a[2]), 3);
        chk("b2b_bits2", 32'(bits_a[2][2:0]), 32'h5);
        chk("b2b_vcnt1", 32'(vcnt_a[1]), 1);
        chk("b2b_bits1", 32'(bits_a[1][0]), 1);
        chk("b2b_others", 32'(vcnt_a[0] + vcnt_a[3]), 0);
        chk("b2b_done",  32'(done_a_cnt), 2);
        chk("b2b_err",   32'(err_a_cnt), 0);
        chk("b2b_no_idle", 32'(busy_drops), 0);
        chk("b2b_port",  32'(cp_a), 1);
        chk("b2b_len",   32'(cl_a), 1);

        // Reset right after the 2nd payload bit.
        clear_counts();
        frame(1'b0, 32'(9'b0_10_0011_10), 9, 0);
        chk("mid_valid_pre", 32'(pv_a), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", 32'(pv_a), 0);
        chk("mid_data",  32'(pd_a), 0);
        chk("mid_port",  32'(cp_a), 0);
        chk("mid_len",   32'(cl_a), 0);
        chk("mid_flags", 32'({busy_a, done_a, err_a}), 0);
        en_a = 1'b1; ser_a = 1'b1;
        tick(); tick();
        rst = 1'b0;
        en_a = 1'b0;
        repeat (3) tick();
        chk("mid_no_done", 32'(done_a_cnt + err_a_cnt), 0);
        chk("mid_vcnt2",   32'(vcnt_a[2]), 2);
        chk("mid_busy",    32'(busy_a), 0);
        clear_counts();
        frame(1'b0, 32'(11'b0_10_0011_101_1), 11, 3);
        frame(1'b0, 32'h1, 1, 3);
        chk("post_vcnt2", 32'(vcnt_a[2]), 3);
        chk("post_bits2", 32'(bits_a[2][2:0]), 32'h5);
        chk("post_done",  32'(done_a_cnt), 1);
        chk("post_err",   32'(err_a_cnt), 0);

        // Instance B: port 5, len 2, payload 11, no parity trailer.
        clear_counts();
        frame(1'b1, 32'(11'b0_101_00010_11), 11, 3);
        chk("b_done_at_last_payload", 32'(done_idx), 10);
        frame(1'b1, 32'h1, 1, 3);
        chk("b_vcnt5",  32'(vcnt_b[5]), 2);
        chk("b_bits5",  32'(bits_b[5][1:0]), 32'h3);
        chk("b_others", 32'(vcnt_b[0] + vcnt_b[1] + vcnt_b[2] + vcnt_b[3]
                            + vcnt_b[4] + vcnt_b[6] + vcnt_b[7]), 0);
        chk("b_port",   32'(cp_b), 5);
        chk("b_len",    32'(cl_b), 2);
        chk("b_done",   32'(done_b_cnt), 1);
        chk("b_err",    32'(err_b_cnt), 0);
        chk("b_busy_end", 32'(busy_b), 0);
        chk("b_a_quiet", 32'(done_a_cnt + vcnt_a[0] + vcnt_a[1] + vcnt_a[2] + vcnt_a[3]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
